// File: rtl/per_gen.sv
// per_gen: programmable square-wave burst generator.
// Emits N periods of P ms at 50% duty, then pulses o_done.
module per_gen #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned PERIOD_W = 10,
  parameter int unsigned COUNT_W  = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic [COUNT_W-1:0]  i_count,
  output logic                o_signal,
  output logic                o_ready,
  output logic                o_done,
  output logic [COUNT_W-1:0]  o_left
);

  localparam int unsigned HALF = CLK_FREQ / 2000;
  localparam int unsigned PRESC_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(HALF - 1);

  localparam logic [1:0] E_IDLE = 2'd0;
  localparam logic [1:0] E_HIGH = 2'd1;
  localparam logic [1:0] E_LOW  = 2'd2;
  localparam logic [1:0] E_DONE = 2'd3;

  logic [1:0]          r_state;
  logic [PRESC_W-1:0]  r_presc;
  logic [PERIOD_W-1:0] r_phase;
  logic [PERIOD_W-1:0] r_period;
  logic [COUNT_W-1:0]  r_left;
  logic                r_signal;
  logic                tick;
  logic                phase_end;
  logic                start_bad;

  // half-ms tick and end of a P-tick phase
  always_comb begin
    tick      = (r_presc == PRESC_MAX);
    phase_end = tick && (r_phase == r_period - 1'b1);
    start_bad = (i_period == '0) || (i_count == '0);
  end

  // burst sequencer: prescaler, phase counter, period counter, FSM
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= E_IDLE;
      r_presc  <= '0;
      r_phase  <= '0;
      r_period <= '0;
      r_left   <= '0;
      r_signal <= 1'b0;
    end else begin
      unique case (r_state)
        E_IDLE: begin
          if (i_start) begin
            r_presc <= '0;
            r_phase <= '0;
            if (start_bad) begin
              r_state <= E_DONE;
            end else begin
              r_period <= i_period;
              r_left   <= i_count;
              r_state  <= E_HIGH;
              r_signal <= 1'b1;
            end
          end
        end
        E_HIGH, E_LOW: begin
          if (tick) begin
            r_presc <= '0;
            r_phase <= phase_end ? '0 : r_phase + 1'b1;
          end else begin
            r_presc <= r_presc + 1'b1;
          end
          if (phase_end) begin
            if (r_state == E_HIGH) begin
              r_state  <= E_LOW;
              r_signal <= 1'b0;
            end else if (r_left > COUNT_W'(1)) begin
              r_left   <= r_left - 1'b1;
              r_state  <= E_HIGH;
              r_signal <= 1'b1;
            end else begin
              r_left  <= '0;
              r_state <= E_DONE;
            end
          end
        end
        E_DONE: r_state <= E_IDLE;
        default: r_state <= E_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the state register
  always_comb begin
    o_signal = r_signal;
    o_ready  = (r_state == E_IDLE);
    o_done   = (r_state == E_DONE);
    o_left   = r_left;
  end

endmodule

// File: tb/tb_per_gen.sv
// tb_per_gen: randomized and directed bursts against a
// time-based reference of the expected waveform.
module tb_per_gen;

  localparam int unsigned CLK_FREQ = 20_000;
  localparam int unsigned PERIOD_W = 10;
  localparam int unsigned COUNT_W  = 8;
  localparam int HALF = CLK_FREQ / 2000;

  logic                clk = 1'b0;
  logic                i_rst = 1'b1;
  logic                i_start = 1'b0;
  logic [PERIOD_W-1:0] i_period = '0;
  logic [COUNT_W-1:0]  i_count = '0;
  logic                o_signal;
  logic                o_ready;
  logic                o_done;
  logic [COUNT_W-1:0]  o_left;

  int vecs = 0;
  int errs = 0;

  per_gen #(
    .CLK_FREQ(CLK_FREQ),
    .PERIOD_W(PERIOD_W),
    .COUNT_W (COUNT_W)
  ) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_period(i_period),
    .i_count (i_count),
    .o_signal(o_signal),
    .o_ready (o_ready),
    .o_done  (o_done),
    .o_left  (o_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".sig"}, 32'(o_signal), 0);
    chk({tag, ".rdy"}, 32'(o_ready), 1);
    chk({tag, ".done"}, 32'(o_done), 0);
    chk({tag, ".left"}, 32'(o_left), 0);
  endtask

  // Expected waveform as a function of cycles t since the start edge:
  // period k occupies [2*k*ph, 2*(k+1)*ph), high in its first half.
  task automatic burst(input int p, input int n,
                       input bit hold, input int rst_at);
    int ph;
    int total;
    ph = p * HALF;
    total = (p == 0 || n == 0) ? 0 : 2 * ph * n;
    i_start  = 1'b1;
    i_period = PERIOD_W'(p);
    i_count  = COUNT_W'(n);
    @(negedge clk);
    if (!hold) i_start = 1'b0;
    for (int t = 0; t <= total + 1; t++) begin
      if (t == rst_at) begin
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        chk_idle("rst_mid");
        @(negedge clk);
        chk_idle("rst_after");
        return;
      end
      if (t < total) begin
        chk("sig", 32'(o_signal), 32'(((t / ph) % 2) == 0));
        chk("left", 32'(o_left), 32'(n - t / (2 * ph)));
        chk("rdy_busy", 32'(o_ready), 0);
        chk("done_busy", 32'(o_done), 0);
      end else if (t == total) begin
        chk("done_pulse", 32'(o_done), 1);
        chk("rdy_done", 32'(o_ready), 0);
        chk("sig_done", 32'(o_signal), 0);
        chk("left_done", 32'(o_left), 0);
      end else begin
        chk("rdy_back", 32'(o_ready), 1);
        chk("done_off", 32'(o_done), 0);
        chk("sig_idle", 32'(o_signal), 0);
      end
      if (hold && t > 0 && t < total)
        i_period = PERIOD_W'($urandom);
      if (t == total) i_period = PERIOD_W'(p);
      if (t <= total) @(negedge clk);
    end
  endtask

  initial begin
    int p;
    int n;
    int gap;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    i_rst = 1'b0;
    @(negedge clk);
    chk_idle("post_reset");

    burst(3, 2, 1'b0, -1);
    burst(0, 5, 1'b0, -1);
    burst(4, 0, 1'b0, -1);

    burst(1, 1, 1'b1, -1);
    burst(1, 1, 1'b0, -1);

    burst(2, 3, 1'b0, 2 * 2 * HALF + HALF);
    burst(2, 3, 1'b0, -1);

    for (int k = 0; k < 15; k++) begin
      p = $urandom_range(0, 5);
      n = $urandom_range(0, 4);
      burst(p, n, 1'b0, -1);
      gap = $urandom_range(0, 4);
      for (int g = 0; g < gap; g++) begin
        i_period = PERIOD_W'($urandom);
        i_count  = COUNT_W'($urandom);
        @(negedge clk);
        chk_idle("gap");
      end
    end

    burst(1023, 1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
